dbg_bus_responder: RTL and testbench
====================================

Name: dbg_bus_responder

Overview:
- Bus responder for the debug system-bus access host port. It answers the req/gnt/r_valid protocol that the SBA master drives.
- Backed by a byte-enabled word memory with parameterised grant and response latencies.
- Used as the simulation/FPGA target behind the debug module's system-bus master, and as a small scratch RAM on the debug subsystem bus.

Parameters:
- BusWidth, 32, data/address width; must be 32.
- Depth, 256, memory words; power of two, ≥ 2.
- BaseAddr, 32'h0000_0000, byte address of word 0; must be aligned to Depth*4.
- GntLatency, 0, extra cycles req_i is held before gnt_o (0..15).
- RespLatency, 1, cycles from grant to r_valid_o (1..15).
- ErrData, 32'hBADC_AB1E, read data returned for out-of-range reads.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  1  request valid, held until granted
- addr_i  in  BusWidth  byte address
- we_i  in  1  1 = write
- wdata_i  in  BusWidth  write data
- be_i  in  BusWidth/8  byte enables
- gnt_o  out  1  request accepted; one-cycle pulse
- r_valid_o  out  1  response valid; one-cycle pulse, issued for reads and writes
- r_rdata_o  out  BusWidth  read data; valid only with r_valid_o
- err_o  out  1  sticky out-of-range access flag
- err_clr_i  in  1  clears err_o

Behaviour:
- Reset (asynchronous, immediate): state IDLE; gnt_o=0, r_valid_o=0, r_rdata_o=0, err_o=0, counters=0.
- Memory contents are not reset and are preserved across rst_i.
- FSM states: IDLE, WAIT_GNT, RESP.
  - IDLE: if req_i and GntLatency==0, gnt_o=1 combinationally this cycle, go to RESP. If req_i and GntLatency>0, load wait counter = GntLatency-1, go to WAIT_GNT.
  - WAIT_GNT: decrement each cycle. When the counter is 0 and req_i=1, gnt_o=1, go to RESP. If req_i drops, return to IDLE with no grant (tolerated protocol violation).
  - RESP: load response counter = RespLatency-1 at grant. Decrement each cycle. At 0, r_valid_o=1 for exactly one cycle, then IDLE.
- Single outstanding transaction; no grant in RESP. Back-to-back throughput = GntLatency + RespLatency + 1 cycles (first req in IDLE).
- Access is performed in the grant cycle:
  - Writes commit per byte, where be_i[k]=1.
  - Reads capture the word into the response register.
  - A read granted the cycle after a write to the same word returns the new data.
- Word index = (addr_i - BaseAddr) >> 2, truncated to $clog2(Depth) bits; addr_i[1:0] ignored.
- In-range test: addr_i - BaseAddr < Depth*4, computed unsigned in BusWidth bits.
- Out-of-range access:
  - Writes are dropped; reads return ErrData.
  - err_o is set from the cycle after the grant.
  - Write responses still pulse r_valid_o.
- r_rdata_o is 0 for write responses and holds its value between responses.
- err_clr_i clears err_o next cycle. If a new error is set in the same cycle as err_clr_i, set wins.
- be_i=0 write: no memory change, normal response.
- rst_i asserted mid-transaction: the pending response is discarded, and no r_valid_o is issued after reset deassertion. A write already granted stays committed.

Decomposition:
- Package dbg_bus_pkg:
  - bus_req_t {addr, we, wdata, be}
  - resp_state_e {IDLE, WAIT_GNT, RESP}
  - default ErrData constant
- Sub-module dbg_bus_ram: Depth x BusWidth storage; single port, synchronous write with byte enables, combinational read; no reset.
- Top: FSM, latency counters, address decode, error flag.

Test Plan:
- Defaults: write 0x12345678 to 0x10 with be=4'hF -> gnt in the same cycle, r_valid 1 cycle later. Read 0x10 -> rdata=0x12345678.
- Byte enables: word 0x20 holds 0xFFFFFFFF; write 0x00AA00BB with be=4'b0101 -> read returns 0xFFAAFFBB.
- Latency: GntLatency=3, RespLatency=4 -> gnt 3 cycles after req rises, r_valid 4 cycles after gnt. Back-to-back reqs are spaced 8 cycles apart.
- Out of range:
  - Depth=256: read 0x400 -> rdata=0xBADCAB1E, err_o=1.
  - Write 0x400 -> memory unchanged, r_valid still pulses.
  - err_clr_i pulse -> err_o=0.
  - Error and clear in the same cycle -> err_o stays 1.
- Reset in RESP: assert rst_i 1 cycle after gnt (RespLatency=4) -> outputs 0 immediately, no r_valid after release. Previously written word unchanged.
- Req withdrawn: GntLatency=2, req high 1 cycle then low -> no gnt, FSM back in IDLE. Next req is granted normally.

Source files
------------

// File: rtl/dbg_bus_pkg.sv
// Shared types and constants for the debug system-bus responder.
//   bus_req_t    : one request beat as seen on the req/gnt port
//   resp_state_e : responder FSM states
//   DefaultErrData : read data returned for out-of-range reads
package dbg_bus_pkg;

  localparam int unsigned BusW = 32;
  localparam int unsigned BeW  = BusW / 8;

  localparam logic [BusW-1:0] DefaultErrData = 32'hBADC_AB1E;

  typedef struct packed {
    logic [BusW-1:0] addr;
    logic            we;
    logic [BusW-1:0] wdata;
    logic [BeW-1:0]  be;
  } bus_req_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    RESP     = 2'd2
  } resp_state_e;

endpackage

// File: rtl/dbg_bus_ram.sv
// Single-port word RAM with per-byte write enables and combinational read.
// Contents are deliberately not reset.
//   clk_i   : clock
//   we_i    : write strobe (commits on the rising edge)
//   addr_i  : word index
//   wdata_i : write data
//   be_i    : byte enables for the write
//   rdata_o : combinational read of the addressed word
module dbg_bus_ram #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 32,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned BeW   = Width / 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [BeW-1:0]   be_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem [Depth];

  // Byte-granular write
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned k = 0; k < BeW; k++) begin
        if (be_i[k]) mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/dbg_bus_responder.sv
// Req/gnt/r_valid bus responder backed by a byte-enabled word RAM, with
// parameterised grant and response latencies and a sticky range-error flag.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : request, held until granted
//   addr_i       : byte address (bits [1:0] ignored)
//   we_i         : 1 = write
//   wdata_i      : write data
//   be_i         : byte enables
//   gnt_o        : one-cycle grant (combinational from req_i)
//   r_valid_o    : one-cycle response pulse for reads and writes
//   r_rdata_o    : read data, 0 for writes, held between responses
//   err_o        : sticky out-of-range flag
//   err_clr_i    : clears err_o (a simultaneous new error wins)
module dbg_bus_responder
  import dbg_bus_pkg::*;
#(
  parameter int unsigned          BusWidth    = 32,
  parameter int unsigned          Depth       = 256,
  parameter logic [BusWidth-1:0]  BaseAddr    = '0,
  parameter int unsigned          GntLatency  = 0,
  parameter int unsigned          RespLatency = 1,
  parameter logic [BusWidth-1:0]  ErrData     = DefaultErrData
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [BusWidth-1:0]   addr_i,
  input  logic                  we_i,
  input  logic [BusWidth-1:0]   wdata_i,
  input  logic [BusWidth/8-1:0] be_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [BusWidth-1:0]   r_rdata_o,
  output logic                  err_o,
  input  logic                  err_clr_i
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = 4;

  localparam logic [BusWidth-1:0] RangeBytes = BusWidth'(Depth * 4);
  localparam logic [CntW-1:0] GntLoad  = (GntLatency == 0) ? '0 : CntW'(GntLatency - 1);
  localparam logic [CntW-1:0] RespLoad = CntW'(RespLatency - 1);
  localparam bit GntImmediate  = (GntLatency == 0);
  localparam bit RespImmediate = (RespLatency == 1);

  bus_req_t            req;
  resp_state_e         state_q;
  logic [CntW-1:0]     wait_cnt_q;
  logic [CntW-1:0]     resp_cnt_q;
  logic [BusWidth-1:0] resp_data_q;
  logic [BusWidth-1:0] offset;
  logic                in_range;
  logic [AddrW-1:0]    word_idx;
  logic [BusWidth-1:0] ram_rdata;
  logic                ram_we;
  logic                gnt;
  logic [BusWidth-1:0] gnt_data;

  assign req = '{addr: addr_i, we: we_i, wdata: wdata_i, be: be_i};

  // Address decode: unsigned offset from the base, wrap-around lands out of range
  assign offset   = req.addr - BaseAddr;
  assign in_range = offset < RangeBytes;
  assign word_idx = offset[AddrW+1:2];

  // Grant decode; the access itself happens in the grant cycle
  always_comb begin
    gnt = 1'b0;
    unique case (state_q)
      IDLE:     gnt = req_i & GntImmediate;
      WAIT_GNT: gnt = req_i & (wait_cnt_q == '0);
      default:  gnt = 1'b0;
    endcase
  end

  assign gnt_o    = gnt;
  assign ram_we   = gnt & req.we & in_range;
  assign gnt_data = req.we ? '0 : (in_range ? ram_rdata : ErrData);

  dbg_bus_ram #(
    .Depth (Depth),
    .Width (BusWidth)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .addr_i  (word_idx),
    .wdata_i (req.wdata),
    .be_i    (req.be),
    .rdata_o (ram_rdata)
  );

  // FSM, latency counters, registered response and error flag.
  // r_valid_o is launched one edge early so it is a clean register output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      resp_cnt_q  <= '0;
      resp_data_q <= '0;
      r_valid_o   <= 1'b0;
      r_rdata_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      r_valid_o <= 1'b0;

      if (gnt && !in_range) err_o <= 1'b1;
      else if (err_clr_i)   err_o <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (req_i && !GntImmediate) begin
            state_q    <= WAIT_GNT;
            wait_cnt_q <= GntLoad;
          end
        end
        WAIT_GNT: begin
          if (!req_i)                 state_q    <= IDLE;
          else if (wait_cnt_q != '0)  wait_cnt_q <= wait_cnt_q - CntW'(1);
        end
        RESP: begin
          if (resp_cnt_q == '0) state_q    <= IDLE;
          else                  resp_cnt_q <= resp_cnt_q - CntW'(1);
          if (resp_cnt_q == CntW'(1)) begin
            r_valid_o <= 1'b1;
            r_rdata_o <= resp_data_q;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Grant overrides the per-state update above
      if (gnt) begin
        state_q     <= RESP;
        resp_cnt_q  <= RespLoad;
        resp_data_q <= gnt_data;
        if (RespImmediate) begin
          r_valid_o <= 1'b1;
          r_rdata_o <= gnt_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_dbg_bus_responder.sv
// Bench for dbg_bus_responder: two instances (default latencies, and
// GntLatency=3/RespLatency=4 at a non-zero base) against a cycle-keyed
// behavioural model of grants, responses, memory and the error flag.
module tb_dbg_bus_responder;

  localparam int NI = 2;
  localparam logic [31:0] ERR = 32'hBADC_AB1E;

  function automatic int gl(int i);  return (i == 0) ? 0 : 3; endfunction
  function automatic int rl(int i);  return (i == 0) ? 1 : 4; endfunction
  function automatic logic [31:0] base(int i); return (i == 0) ? 32'h0 : 32'h1000; endfunction
  function automatic int key(int i, int c); return i * 1000000 + c; endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]       rst = '0;
  logic [NI-1:0]       req = '0;
  logic [NI-1:0][31:0] addr = '0;
  logic [NI-1:0]       we = '0;
  logic [NI-1:0][31:0] wdata = '0;
  logic [NI-1:0][3:0]  be = '0;
  logic [NI-1:0]       err_clr = '0;
  logic [NI-1:0]       gnt;
  logic [NI-1:0]       rv;
  logic [NI-1:0][31:0] rdata;
  logic [NI-1:0]       err;

  dbg_bus_responder #(.GntLatency(0), .RespLatency(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]),
    .wdata_i(wdata[0]), .be_i(be[0]), .gnt_o(gnt[0]), .r_valid_o(rv[0]),
    .r_rdata_o(rdata[0]), .err_o(err[0]), .err_clr_i(err_clr[0]));

  dbg_bus_responder #(.BaseAddr(32'h1000), .GntLatency(3), .RespLatency(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]),
    .wdata_i(wdata[1]), .be_i(be[1]), .gnt_o(gnt[1]), .r_valid_o(rv[1]),
    .r_rdata_o(rdata[1]), .err_o(err[1]), .err_clr_i(err_clr[1]));

  // Model state
  int                  cyc = 0;
  bit [31:0]           mem_m [NI][256];
  bit [NI-1:0]         err_m = '0;
  logic [NI-1:0][31:0] last_rd = '0;
  bit                  exp_g   [int];
  bit [31:0]           exp_rv  [int];
  bit                  exp_oor [int];
  int                  busy_until [NI];
  int                  pend_rv [NI];
  int                  last_issue [NI];
  int                  last_g [NI];
  int                  prev_g [NI];
  int                  last_rv [NI];
  bit [NI-1:0]         clr_rand = '0;
  int                  checks = 0;
  int                  errors = 0;

  task automatic chk(string name, int i, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d got %h exp %h", name, i, cyc, got, exp);
    end
  endtask

  // Error flag model and cycle count, advanced on every rising edge
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst[i])                         err_m[i] = 1'b0;
      else if (exp_oor.exists(key(i, cyc))) err_m[i] = 1'b1;
      else if (err_clr[i])                err_m[i] = 1'b0;
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison of every output of both instances
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst[i]) begin
        chk("rst_gnt", i, 32'(gnt[i]), 32'd0);
        chk("rst_r_valid", i, 32'(rv[i]), 32'd0);
        chk("rst_r_rdata", i, rdata[i], 32'd0);
        chk("rst_err", i, 32'(err[i]), 32'd0);
      end else begin
        chk("gnt", i, 32'(gnt[i]), 32'(exp_g.exists(key(i, cyc))));
        if (gnt[i] === 1'b1) begin prev_g[i] = last_g[i]; last_g[i] = cyc; end
        if (exp_rv.exists(key(i, cyc))) begin
          chk("r_valid", i, 32'(rv[i]), 32'd1);
          last_rd[i] = exp_rv[key(i, cyc)];
        end else begin
          chk("r_valid", i, 32'(rv[i]), 32'd0);
        end
        if (rv[i] === 1'b1) last_rv[i] = cyc;
        chk("r_rdata", i, rdata[i], last_rd[i]);
        chk("err", i, 32'(err[i]), 32'(err_m[i]));
      end
    end
  end

  task automatic tick(int i);
    @(posedge clk);
    #1;
    if (clr_rand[i]) err_clr[i] = ($urandom_range(0, 3) == 0);
  endtask

  // One transaction: schedule its expected grant/response, then drive it
  task automatic txn(int i, logic [31:0] a, logic w, logic [31:0] d, logic [3:0] b, bit clr_at_gnt);
    int c;
    int g;
    int v;
    int idx;
    logic [31:0] off;
    bit oor;
    bit [31:0] rd;
    while (cyc < busy_until[i]) tick(i);
    c   = cyc;
    g   = c + gl(i);
    v   = g + rl(i);
    off = a - base(i);
    oor = (off >= 32'd1024);
    idx = int'(off[9:2]);
    rd  = '0;
    if (!w) rd = oor ? ERR : mem_m[i][idx];
    else if (!oor) begin
      for (int k = 0; k < 4; k++) if (b[k]) mem_m[i][idx][8*k +: 8] = d[8*k +: 8];
    end
    exp_g[key(i, g)] = 1'b1;
    exp_rv[key(i, v)] = rd;
    if (oor) exp_oor[key(i, g)] = 1'b1;
    pend_rv[i]    = key(i, v);
    busy_until[i] = v + 1;
    last_issue[i] = c;
    req[i] = 1'b1; addr[i] = a; we[i] = w; wdata[i] = d; be[i] = b;
    if (clr_at_gnt && gl(i) == 0) err_clr[i] = 1'b1;
    for (int n = 0; n < gl(i); n++) begin
      tick(i);
      if (clr_at_gnt && n == gl(i) - 1) err_clr[i] = 1'b1;
    end
    tick(i);
    req[i] = 1'b0; addr[i] = $urandom; we[i] = 1'($urandom_range(0, 1));
    wdata[i] = $urandom; be[i] = 4'($urandom);
    if (clr_at_gnt) err_clr[i] = 1'b0;
  endtask

  task automatic rand_txn(int i);
    int sel;
    logic [31:0] a;
    sel = $urandom_range(0, 9);
    if (sel < 8)       a = base(i) + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
    else if (sel == 8) a = base(i) + 32'h400 + ($urandom & 32'h0000_FFFC);
    else               a = base(i) - 32'd4 - 32'($urandom_range(0, 3));
    txn(i, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), 1'b0);
  endtask

  // Request raised for one cycle then withdrawn before the grant
  task automatic withdraw(int i);
    while (cyc < busy_until[i]) tick(i);
    req[i] = 1'b1; addr[i] = base(i); we[i] = 1'b1; wdata[i] = 32'hDEAD_BEEF; be[i] = 4'hF;
    busy_until[i] = cyc + 2;
    tick(i);
    req[i] = 1'b0;
  endtask

  task automatic do_reset(int i, int n);
    rst[i] = 1'b1; req[i] = 1'b0; err_clr[i] = 1'b0;
    if (exp_rv.exists(pend_rv[i]) && pend_rv[i] >= key(i, cyc)) exp_rv.delete(pend_rv[i]);
    last_rd[i] = '0;
    repeat (n) tick(i);
    rst[i] = 1'b0;
    busy_until[i] = cyc;
  endtask

  task automatic expect_rd(int i, logic [31:0] exp, string name);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (rv[i] === 1'b1) begin
        seen = 1'b1;
        chk(name, i, rdata[i], exp);
      end
    end
    if (!seen) chk({name, "_timeout"}, i, 32'd0, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc%0d got timeout exp finish", cyc);
    $fatal(1);
  end

  initial begin
    int lg;
    for (int i = 0; i < NI; i++) begin
      busy_until[i] = 0; pend_rv[i] = -1; last_issue[i] = 0;
      last_g[i] = 0; prev_g[i] = 0; last_rv[i] = 0;
    end
    #1 rst = '1;
    repeat (3) @(posedge clk);
    #1 rst = '0;
    chk("post_rst_rdata", 0, rdata[0], 32'd0);
    chk("post_rst_err", 1, 32'(err[1]), 32'd0);

    // ---------------- instance 0: GntLatency 0, RespLatency 1 ----------------
    for (int w = 0; w < 16; w++) txn(0, base(0) + 32'(w * 4), 1'b1, $urandom, 4'hF, 1'b0);

    txn(0, 32'h10, 1'b1, 32'h1234_5678, 4'hF, 1'b0);
    txn(0, 32'h10, 1'b0, 32'h0, 4'hF, 1'b0);
    expect_rd(0, 32'h1234_5678, "rd_default");
    tick(0);
    chk("gnt_lat0", 0, 32'(last_g[0] - last_issue[0]), 32'd0);
    chk("rv_lat0", 0, 32'(last_rv[0] - last_g[0]), 32'd1);

    txn(0, 32'h20, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0);
    txn(0, 32'h20, 1'b1, 32'h00AA_00BB, 4'b0101, 1'b0);
    txn(0, 32'h22, 1'b0, 32'h0, 4'hF, 1'b0);
    expect_rd(0, 32'hFFAA_FFBB, "rd_be");

    txn(0, 32'h24, 1'b1, 32'h1111_1111, 4'hF, 1'b0);
    txn(0, 32'h24, 1'b1, 32'h2222_2222, 4'h0, 1'b0);
    txn(0, 32'h24, 1'b0, 32'h0, 4'hF, 1'b0);
    expect_rd(0, 32'h1111_1111, "rd_be_zero");

    txn(0, 32'h0, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0);
    txn(0, 32'h400, 1'b0, 32'h0, 4'hF, 1'b0);
    expect_rd(0, ERR, "rd_oor");
    chk("err_set", 0, 32'(err[0]), 32'd1);
    txn(0, 32'h400, 1'b1, 32'h0BAD_0BAD, 4'hF, 1'b0);
    expect_rd(0, 32'h0, "wr_oor_resp");
    txn(0, 32'h0, 1'b0, 32'h0, 4'hF, 1'b0);
    expect_rd(0, 32'hCAFE_F00D, "rd_alias_unchanged");

    tick(0);
    err_clr[0] = 1'b1;
    tick(0);
    err_clr[0] = 1'b0;
    chk("err_clr", 0, 32'(err[0]), 32'd0);

    txn(0, 32'h800, 1'b0, 32'h0, 4'hF, 1'b1);
    expect_rd(0, ERR, "rd_oor2");
    chk("err_set_wins", 0, 32'(err[0]), 32'd1);

    clr_rand[0] = 1'b1;
    repeat (150) rand_txn(0);
    clr_rand[0] = 1'b0;
    tick(0);
    err_clr[0] = 1'b0;

    // ---------------- instance 1: GntLatency 3, RespLatency 4 ----------------
    for (int w = 0; w < 16; w++) txn(1, base(1) + 32'(w * 4), 1'b1, $urandom, 4'hF, 1'b0);

    txn(1, 32'h1010, 1'b1, 32'hA5A5_A5A5, 4'hF, 1'b0);
    lg = last_issue[1];
    txn(1, 32'h1010, 1'b0, 32'h0, 4'hF, 1'b0);
    expect_rd(1, 32'hA5A5_A5A5, "rd_lat");
    tick(1);
    chk("gnt_lat", 1, 32'(prev_g[1] - lg), 32'd3);
    chk("b2b_spacing", 1, 32'(last_g[1] - prev_g[1]), 32'd8);
    chk("rv_lat", 1, 32'(last_rv[1] - last_g[1]), 32'd4);

    txn(1, 32'h1400, 1'b0, 32'h0, 4'hF, 1'b0);
    expect_rd(1, ERR, "rd_oor_base");
    txn(1, 32'h1030, 1'b1, 32'h5A5A_5A5A, 4'hF, 1'b0);
    do_reset(1, 2);
    repeat (8) tick(1);
    chk("rst_err_cleared", 1, 32'(err[1]), 32'd0);
    txn(1, 32'h1030, 1'b0, 32'h0, 4'hF, 1'b0);
    expect_rd(1, 32'h5A5A_5A5A, "rd_after_rst");
    txn(1, 32'h1010, 1'b0, 32'h0, 4'hF, 1'b0);
    expect_rd(1, 32'hA5A5_A5A5, "rd_prev_unchanged");

    tick(1);
    lg = last_g[1];
    withdraw(1);
    repeat (6) tick(1);
    chk("no_gnt_withdraw", 1, 32'(last_g[1]), 32'(lg));
    txn(1, 32'h1010, 1'b0, 32'h0, 4'hF, 1'b0);
    expect_rd(1, 32'hA5A5_A5A5, "rd_after_withdraw");

    clr_rand[1] = 1'b1;
    repeat (40) rand_txn(1);
    clr_rand[1] = 1'b0;
    tick(1);
    err_clr[1] = 1'b0;
    repeat (10) tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
